seq_adder_flags: RTL and testbench
==================================

Name: seq_adder_flags

Overview:
- Parametrised, multi-cycle successor to the team's 16-bit flag adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, with the carry rippling through a registered carry between slices.
- Produces the same status flags (sign, zero, carry, parity, overflow), behind valid/ready handshakes on both sides.
- Sits between operand registers and the datapath status register. It trades latency for a short carry chain in wide configurations.

Parameters:
- WIDTH, 16: operand/result width. Must be an integer multiple of CHUNK.
- CHUNK, 4: bits processed per cycle, 1..WIDTH. CHUNK=WIDTH gives a single-slice adder.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands and mode present.
- in_ready, output, 1: block can accept a new operation.
- in_x, input, WIDTH: operand x.
- in_y, input, WIDTH: operand y.
- in_mode, input, 2: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- in_cin, input, 1: carry-in, used by ADC/SBB only.
- out_valid, output, 1: result and flags valid.
- out_ready, input, 1: consumer accepts the result.
- out_z, output, WIDTH: result.
- out_sign, output, 1: out_z[WIDTH-1].
- out_zero, output, 1: 1 when out_z == 0.
- out_carry, output, 1: carry out of the MSB (SUB/SBB: 1 = no borrow).
- out_parity, output, 1: even parity, XNOR-reduce of out_z.
- out_overflow, output, 1: signed overflow.
- busy, output, 1: high in RUN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_z=0, all flags 0, slice counter=0, internal carry=0.
- Operand conditioning: at accept, latch x, y' and c0.
  - y' = in_y for ADD/ADC, ~in_y for SUB/SBB.
  - c0 = 0 (ADD), 1 (SUB), in_cin (ADC, SBB).
- States:
  - IDLE: in_ready=1. On in_valid, latch operands and go to RUN with slice index i=0.
  - RUN: each cycle compute {c, s} = x[i] + y'[i] + c over CHUNK bits, write s into out_z slice i and register c.
    - i increments each cycle.
    - After slice N-1 (N=WIDTH/CHUNK), go to DONE.
    - in_ready=0 throughout RUN.
  - DONE: out_valid=1; results and flags are stable and held while out_ready=0. When out_valid && out_ready, go to IDLE.
- Latency: accept at edge k; out_valid is high after edge k+N. Throughput is one operation per N+2 cycles; in_ready is not asserted in DONE.
- Flags, registered on entering DONE:
  - out_carry = final slice carry.
  - out_overflow = carry into MSB XOR carry out of MSB, taken from the last slice.
  - Sign, zero and parity are derived from the full out_z.
- Width rules: all arithmetic is modulo 2^WIDTH; carry beyond WIDTH appears only in out_carry.
- Boundary conditions:
  - CHUNK=WIDTH: N=1, latency 1.
  - in_valid while busy or in DONE: ignored, no latching.
  - in_mode/in_cin sampled only at accept.
  - rst in any state (including mid-RUN or with out_valid held): returns to IDLE with reset values on the next edge; the partial result is discarded.
  - rst has priority over every handshake event.
- Illegal parameters (WIDTH % CHUNK != 0, or CHUNK == 0): elaboration-time error.

Decomposition:
- Shared package seq_adder_pkg holds:
  - mode encodings MODE_ADD/MODE_SUB/MODE_ADC/MODE_SBB;
  - state encodings S_IDLE/S_RUN/S_DONE.
- One sub-module, chunk_adder: CHUNK-bit combinational slice with ports a, b, cin, s, cout, and carry into its MSB for overflow.
- The top holds the FSM, slice counter, operand/result registers and flag logic.

Test Plan:
- WIDTH=16, CHUNK=4, ADD 8fff+8000: out_z=0fff, c=1, ov=1, s=0, zr=0, p=1; out_valid 4 cycles after accept.
- ADD fafe+0002 -> z=fb00, c=0, ov=0, s=1, p=0. ADD aaaa+5555 -> z=ffff, c=0, ov=0, s=1, p=1.
- SUB 0005-0005 -> z=0000, c=1, zr=1, p=1, ov=0. SUB 8000-0001 -> z=7fff, c=1, ov=1, s=0, p=0.
- ADC ffff+0000 with cin=1 -> z=0000, c=1, zr=1, ov=0.
- Backpressure: hold out_ready=0 for 5 cycles -> out_z and flags stable, in_ready=0. A new in_valid during DONE is ignored; the op is accepted only after the out handshake.
- Reset mid-RUN after 2 slices -> next cycle IDLE, out_valid=0, out_z=0. Repeat the 8fff+8000 vector with CHUNK=1 (latency 16) and CHUNK=16 (latency 1): results identical.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared encodings for the sequential flag adder: operation modes and FSM states.
package seq_adder_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ADC = 2'b10;
    localparam logic [1:0] MODE_SBB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its MSB so the
// top can derive signed overflow from the last slice.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        s    = sum[CHUNK-1:0];
        cout = sum[CHUNK];
        // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
        cmsb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/seq_adder_flags.sv
// Multi-cycle add/subtract with status flags: CHUNK bits per clock through a
// registered ripple carry, valid/ready handshakes on input and output.
module seq_adder_flags
    import seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [1:0]       in_mode,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_parity,
    output logic             out_overflow,
    output logic             busy
);

    localparam int unsigned CHUNK_SAFE = (CHUNK == 0) ? 1 : CHUNK;
    localparam int unsigned NSLICE     = WIDTH / CHUNK_SAFE;
    localparam int unsigned CW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
        $error("seq_adder_flags: CHUNK must be nonzero and divide WIDTH");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             parity_q, parity_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_slice, b_slice, s_slice;
    logic             slice_cout, slice_cmsb;

    always_comb begin
        base    = 32'(idx_q) * CHUNK;
        a_slice = x_q[base +: CHUNK];
        b_slice = y_q[base +: CHUNK];
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (c_q),
        .s    (s_slice),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        c_d      = c_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        parity_d = parity_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d   = in_x;
                    idx_d = '0;
                    unique case (in_mode)
                        MODE_SUB: begin y_d = ~in_y; c_d = 1'b1;   end
                        MODE_ADC: begin y_d = in_y;  c_d = in_cin; end
                        MODE_SBB: begin y_d = ~in_y; c_d = in_cin; end
                        default:  begin y_d = in_y;  c_d = 1'b0;   end
                    endcase
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                z_d[base +: CHUNK] = s_slice;
                c_d   = slice_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == CW'(NSLICE - 1)) begin
                    idx_d    = '0;
                    c_d      = 1'b0;
                    sign_d   = z_d[WIDTH-1];
                    zero_d   = (z_d == '0);
                    carry_d  = slice_cout;
                    parity_d = ~^z_d;
                    ovf_d    = slice_cmsb ^ slice_cout;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            c_q      <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            parity_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            c_q      <= c_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            parity_q <= parity_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        in_ready     = (state_q == S_IDLE);
        out_valid    = (state_q == S_DONE);
        busy         = (state_q == S_RUN);
        out_z        = z_q;
        out_sign     = sign_q;
        out_zero     = zero_q;
        out_carry    = carry_q;
        out_parity   = parity_q;
        out_overflow = ovf_q;
    end

endmodule

// File: tb/tb_seq_adder_flags.sv
// Directed bench for seq_adder_flags: CHUNK=4, 1 and 16 instances share operands;
// flag vectors are packed {sign, zero, carry, parity, overflow}.
module tb_seq_adder_flags;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tx = '0;
    logic [15:0] ty = '0;
    logic [1:0]  tmode = 2'b00;
    logic        tcin = 1'b0;
    logic        iv   [3];
    logic        ordy [3];
    wire         ir   [3];
    wire         ovl  [3];
    wire         bsy  [3];
    wire  [15:0] oz   [3];
    wire  [4:0]  ofl  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_adder_flags #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_x(tx), .in_y(ty),
        .in_mode(tmode), .in_cin(tcin), .out_valid(ovl[0]), .out_ready(ordy[0]),
        .out_z(oz[0]), .out_sign(ofl[0][4]), .out_zero(ofl[0][3]), .out_carry(ofl[0][2]),
        .out_parity(ofl[0][1]), .out_overflow(ofl[0][0]), .busy(bsy[0])
    );

    seq_adder_flags #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_x(tx), .in_y(ty),
        .in_mode(tmode), .in_cin(tcin), .out_valid(ovl[1]), .out_ready(ordy[1]),
        .out_z(oz[1]), .out_sign(ofl[1][4]), .out_zero(ofl[1][3]), .out_carry(ofl[1][2]),
        .out_parity(ofl[1][1]), .out_overflow(ofl[1][0]), .busy(bsy[1])
    );

    seq_adder_flags #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_x(tx), .in_y(ty),
        .in_mode(tmode), .in_cin(tcin), .out_valid(ovl[2]), .out_ready(ordy[2]),
        .out_z(oz[2]), .out_sign(ofl[2][4]), .out_zero(ofl[2][3]), .out_carry(ofl[2][2]),
        .out_parity(ofl[2][1]), .out_overflow(ofl[2][0]), .busy(bsy[2])
    );

    // Drives one operation into instance d, waits (bounded) for the result,
    // captures it, then completes the output handshake. lat = -1 on timeout.
    task automatic run_op(input int d, input logic [15:0] x, input logic [15:0] y,
                          input logic [1:0] m, input logic c,
                          output int lat, output logic [15:0] z, output logic [4:0] f);
        tx = x; ty = y; tmode = m; tcin = c;
        iv[d] = 1'b1;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ovl[d] === 1'b1) begin
                lat = i;
                break;
            end
        end
        z = oz[d];
        f = ofl[d];
        if (lat > 0) begin
            ordy[d] = 1'b1;
            @(posedge clk); #1;
            ordy[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({ir[d], ovl[d], bsy[d]} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got ir/ov/busy=%b expected 100", d,
                         {ir[d], ovl[d], bsy[d]});
            end
            n_checks++;
            if ({oz[d], ofl[d]} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got z=%h fl=%b expected 0", d, oz[d], ofl[d]);
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  m;
        logic        c;
        logic [15:0] z;
        logic [4:0]  f;
    } vec_t;

    task automatic test_arith();
        vec_t v [9];
        int lat;
        logic [15:0] z;
        logic [4:0] f;
        v[0] = '{"add_8fff_8000", 16'h8fff, 16'h8000, 2'b00, 1'b0, 16'h0fff, 5'b00111};
        v[1] = '{"add_fafe_0002", 16'hfafe, 16'h0002, 2'b00, 1'b0, 16'hfb00, 5'b10000};
        v[2] = '{"add_aaaa_5555", 16'haaaa, 16'h5555, 2'b00, 1'b0, 16'hffff, 5'b10010};
        v[3] = '{"sub_0005_0005", 16'h0005, 16'h0005, 2'b01, 1'b0, 16'h0000, 5'b01110};
        v[4] = '{"sub_8000_0001", 16'h8000, 16'h0001, 2'b01, 1'b0, 16'h7fff, 5'b00101};
        v[5] = '{"adc_ffff_0000", 16'hffff, 16'h0000, 2'b10, 1'b1, 16'h0000, 5'b01110};
        v[6] = '{"sbb_0005_0003", 16'h0005, 16'h0003, 2'b11, 1'b0, 16'h0001, 5'b00100};
        v[7] = '{"add_cin_ignored", 16'h0001, 16'h0001, 2'b00, 1'b1, 16'h0002, 5'b00000};
        v[8] = '{"sub_cin_ignored", 16'h0003, 16'h0001, 2'b01, 1'b0, 16'h0002, 5'b00100};
        foreach (v[i]) begin
            run_op(0, v[i].x, v[i].y, v[i].m, v[i].c, lat, z, f);
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL %s latency: got %0d expected 4", v[i].name, lat);
            end
            n_checks++;
            if (z !== v[i].z) begin
                n_fail++;
                $display("FAIL %s z: got %h expected %h", v[i].name, z, v[i].z);
            end
            n_checks++;
            if (f !== v[i].f) begin
                n_fail++;
                $display("FAIL %s flags: got %b expected %b", v[i].name, f, v[i].f);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        tx = 16'h1234; ty = 16'h1111; tmode = 2'b00; tcin = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        // Keep a different request pending through RUN and DONE.
        tx = 16'h0001; ty = 16'h0001; tmode = 2'b01; tcin = 1'b1;
        n_checks++;
        if ({ir[0], bsy[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_run_ctrl: got ir/busy=%b expected 01", {ir[0], bsy[0]});
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ovl[0] === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected 4", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({oz[0], ofl[0], ir[0], ovl[0]} !== {16'h2345, 5'b00010, 2'b01}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got z=%h fl=%b ir=%b ov=%b expected 2345 00010 0 1",
                         i, oz[0], ofl[0], ir[0], ovl[0]);
            end
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        n_checks++;
        if ({ir[0], ovl[0], bsy[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_after_hs: got ir/ov/busy=%b expected 100", {ir[0], ovl[0], bsy[0]});
        end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        n_checks++;
        if (bsy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second_accept: got busy=%b expected 1", bsy[0]);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ovl[0] === 1'b1) begin
                lat = i;
                break;
            end
        end
        // Pending request was SUB 0001-0001 with cin ignored.
        n_checks++;
        if ({lat == 4, oz[0], ofl[0]} !== {1'b1, 16'h0000, 5'b01110}) begin
            n_fail++;
            $display("FAIL bp_second_op: got lat=%0d z=%h fl=%b expected 4 0000 01110",
                     lat, oz[0], ofl[0]);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [15:0] z;
        logic [4:0] f;
        tx = 16'h8fff; ty = 16'h8000; tmode = 2'b00; tcin = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bsy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got busy=%b expected 1", bsy[0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({ir[0], ovl[0], bsy[0], oz[0], ofl[0]} !== {3'b100, 16'h0000, 5'b00000}) begin
            n_fail++;
            $display("FAIL rst_mid_state: got ir/ov/busy=%b z=%h fl=%b expected 100 0000 00000",
                     {ir[0], ovl[0], bsy[0]}, oz[0], ofl[0]);
        end
        run_op(0, 16'h8fff, 16'h8000, 2'b00, 1'b0, lat, z, f);
        n_checks++;
        if ({lat == 4, z, f} !== {1'b1, 16'h0fff, 5'b00111}) begin
            n_fail++;
            $display("FAIL rst_mid_rerun: got lat=%0d z=%h fl=%b expected 4 0fff 00111",
                     lat, z, f);
        end
    endtask

    task automatic test_chunk_variants();
        int lat;
        logic [15:0] z;
        logic [4:0] f;
        run_op(1, 16'h8fff, 16'h8000, 2'b00, 1'b0, lat, z, f);
        n_checks++;
        if ({lat == 16, z, f} !== {1'b1, 16'h0fff, 5'b00111}) begin
            n_fail++;
            $display("FAIL chunk1: got lat=%0d z=%h fl=%b expected 16 0fff 00111", lat, z, f);
        end
        run_op(2, 16'h8fff, 16'h8000, 2'b00, 1'b0, lat, z, f);
        n_checks++;
        if ({lat == 1, z, f} !== {1'b1, 16'h0fff, 5'b00111}) begin
            n_fail++;
            $display("FAIL chunk16: got lat=%0d z=%h fl=%b expected 1 0fff 00111", lat, z, f);
        end
        run_op(2, 16'h8000, 16'h0001, 2'b01, 1'b0, lat, z, f);
        n_checks++;
        if ({lat == 1, z, f} !== {1'b1, 16'h7fff, 5'b00101}) begin
            n_fail++;
            $display("FAIL chunk16_sub: got lat=%0d z=%h fl=%b expected 1 7fff 00101", lat, z, f);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
        end
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_mid_run();
        test_chunk_variants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
